// File: rtl/strided_stream_reader_pkg.sv
// Shared types for the strided stream reader:
// FSM state encoding and skid buffer sizing.
package strided_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int SKID_DEPTH = 2;

  function automatic logic [1:0] occ_step(
    input logic [1:0] occ,
    input logic       push,
    input logic       pop
  );
    logic [1:0] nxt;
    nxt = occ;
    unique case ({push, pop})
      2'b10:   nxt = occ + 2'd1;
      2'b01:   nxt = occ - 2'd1;
      default: nxt = occ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/strided_stream_reader_skid_buf.sv
// Two-entry valid/ready buffer with flush,
// registered storage and occupancy output.
module stream_skid_buf
  import strided_stream_reader_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         push_ok;
  logic         pop_ok;

  assign out_valid = cnt_q != 2'd0;
  assign pop_ok    = pop & out_valid;
  assign push_ok   = push & ((cnt_q != 2'(SKID_DEPTH)) | pop_ok);
  assign out_data  = mem_q[rd_ptr_q];
  assign occ       = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= occ_step(cnt_q, push_ok, pop_ok);
    end
  end

endmodule

// File: rtl/true_dpbram.sv
// Dual-port block RAM, one clock, registered reads,
// read-first on a same-address write.
module true_dpbram #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 100
) (
  input  logic              clk,
  input  logic              ce0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] din0,
  output logic [DWIDTH-1:0] dout0,
  input  logic              ce1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] din1,
  output logic [DWIDTH-1:0] dout1
);

  localparam logic [AWIDTH:0] DEPTH = MEM_SIZE[AWIDTH:0];

  logic [DWIDTH-1:0] mem [MEM_SIZE];
  logic              ok0;
  logic              ok1;

  // out-of-range accesses read as zero and never write
  assign ok0 = {1'b0, addr0} < DEPTH;
  assign ok1 = {1'b0, addr1} < DEPTH;

  always_ff @(posedge clk) begin
    if (ce0) begin
      dout0 <= ok0 ? mem[addr0] : '0;
      if (we0 && ok0) mem[addr0] <= din0;
    end
    if (ce1) begin
      dout1 <= ok1 ? mem[addr1] : '0;
      if (we1 && ok1) mem[addr1] <= din1;
    end
  end

endmodule

// File: rtl/strided_stream_reader.sv
// Reads base + k*stride (k < len) from BRAM and
// streams it out with backpressure, last flag, abort.
module strided_stream_reader
  import strided_stream_reader_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 7,
  parameter int MEM_SIZE  = 100,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [AWIDTH-1:0]    base_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [AWIDTH-1:0]    stride_i,
  input  logic                 abort_i,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DWIDTH-1:0]    m_data_o,
  output logic                 m_last_o,
  input  logic                 wr_en_i,
  input  logic [AWIDTH-1:0]    wr_addr_i,
  input  logic [DWIDTH-1:0]    wr_data_i
);

  state_t               state_q;
  state_t               state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issued_q;
  logic [AWIDTH-1:0]    stride_q;
  logic [AWIDTH-1:0]    addr_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;

  logic                 issue;
  logic                 issue_last;
  logic [AWIDTH-1:0]    issue_addr;
  logic [AWIDTH-1:0]    issue_stride;

  logic                 active;
  logic                 flush;
  logic                 pop;
  logic                 push;
  logic                 buf_valid;
  logic [DWIDTH:0]      buf_data;
  logic [1:0]           buf_occ;
  logic [2:0]           inflight;
  logic                 credit_ok;
  logic [DWIDTH-1:0]    rd_data;
  logic [DWIDTH-1:0]    wr_rdata_unused;

  assign active    = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign flush     = active & abort_i;
  assign pop       = buf_valid & m_ready_i;
  assign push      = rd_valid_q & ~flush;
  assign inflight  = {1'b0, buf_occ} + {2'b00, rd_valid_q};
  // a pop this cycle frees a slot for a read issued now
  assign credit_ok = inflight < (3'(SKID_DEPTH) + {2'b00, pop});

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    issue_last   = 1'b0;
    issue_addr   = addr_q;
    issue_stride = stride_q;
    case (state_q)
      ST_IDLE: begin
        // first read goes out with the start so data lands a cycle early
        if (start_i) begin
          issue_addr   = base_addr_i;
          issue_stride = stride_i;
          if (len_i != '0) begin
            state_d    = ST_RUN;
            issue      = 1'b1;
            issue_last = len_i == LEN_WIDTH'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (issued_q == len_q) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (issued_q + LEN_WIDTH'(1)) == len_q;
        end
      end
      ST_DRAIN: begin
        if (abort_i) state_d = ST_IDLE;
        else if (pop && buf_data[DWIDTH]) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= issue;
      rd_last_q  <= issue_last;
      if (state_q == ST_IDLE) begin
        if (start_i) begin
          len_q    <= len_i;
          stride_q <= stride_i;
          issued_q <= issue ? LEN_WIDTH'(1) : '0;
        end
      end else if (issue) begin
        issued_q <= issued_q + LEN_WIDTH'(1);
      end
      if (issue) addr_q <= issue_addr + issue_stride;
    end
  end

  true_dpbram #(
    .DWIDTH  (DWIDTH),
    .AWIDTH  (AWIDTH),
    .MEM_SIZE(MEM_SIZE)
  ) u_bram (
    .clk  (clk),
    .ce0  (issue),
    .we0  (1'b0),
    .addr0(issue_addr),
    .din0 ('0),
    .dout0(rd_data),
    .ce1  (wr_en_i),
    .we1  (wr_en_i),
    .addr1(wr_addr_i),
    .din1 (wr_data_i),
    .dout1(wr_rdata_unused)
  );

  stream_skid_buf #(
    .W(DWIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data({rd_last_q, rd_data}),
    .pop      (pop),
    .out_valid(buf_valid),
    .out_data (buf_data),
    .occ      (buf_occ)
  );

  assign idle_o    = state_q == ST_IDLE;
  assign run_o     = active;
  assign done_o    = state_q == ST_DONE;
  assign m_valid_o = buf_valid;
  assign m_data_o  = buf_data[DWIDTH-1:0];
  assign m_last_o  = buf_valid & buf_data[DWIDTH];

endmodule

// File: tb/tb_strided_stream_reader.sv
// Directed bench for strided_stream_reader:
// burst table plus backpressure/abort/reset sequences.
module tb_strided_stream_reader;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int MS = 128;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic [AW-1:0] stride_i = '0;
  logic          abort_i = 1'b0;
  logic          idle_o;
  logic          run_o;
  logic          done_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [DW-1:0] wr_data_i = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  strided_stream_reader #(
    .DWIDTH   (DW),
    .AWIDTH   (AW),
    .MEM_SIZE (MS),
    .LEN_WIDTH(LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .stride_i   (stride_i),
    .abort_i    (abort_i),
    .idle_o     (idle_o),
    .run_o      (run_o),
    .done_o     (done_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i)
  );

  typedef struct {
    int base;
    int len;
    int stride;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v);
    int exp;
    start_i     = 1'b1;
    base_addr_i = v.base[AW-1:0];
    len_i       = v.len[LW-1:0];
    stride_i    = v.stride[AW-1:0];
    m_ready_i   = 1'b1;
    tick();
    start_i = 1'b0;
    check("burst_lat1_valid", m_valid_o, 0);
    check("burst_run", run_o, 1);
    tick();
    for (int k = 0; k < v.len; k++) begin
      exp = 100 + ((v.base + k * v.stride) % 128);
      check("burst_valid", m_valid_o, 1);
      check("burst_data", m_data_o, exp);
      check("burst_last", m_last_o, (k == v.len - 1) ? 1 : 0);
      check("burst_no_done", done_o, 0);
      if (k == 0) check("burst_first", m_data_o, v.exp_first);
      if (k == v.len - 1) check("burst_final", m_data_o, v.exp_last);
      tick();
    end
    check("burst_done", done_o, 1);
    check("burst_done_novalid", m_valid_o, 0);
    tick();
    check("burst_idle", idle_o, 1);
    check("burst_done_clr", done_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] held_data;
    logic          held_last;
    logic          held;
    int            k;
    int            hs;
    logic [3:0]    pat;

    vecs[0] = '{base: 4,   len: 5, stride: 1,   exp_first: 104, exp_last: 108};
    vecs[1] = '{base: 120, len: 3, stride: 5,   exp_first: 220, exp_last: 102};
    vecs[2] = '{base: 7,   len: 1, stride: 3,   exp_first: 107, exp_last: 107};
    vecs[3] = '{base: 0,   len: 4, stride: 127, exp_first: 100, exp_last: 225};

    tick();
    tick();
    check("rst_idle", idle_o, 1);
    check("rst_run", run_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_last", m_last_o, 0);
    check("rst_data", m_data_o, 0);
    rst = 1'b0;

    for (int i = 0; i < MS; i++) begin
      wr_en_i   = 1'b1;
      wr_addr_i = i[AW-1:0];
      wr_data_i = DW'(i + 100);
      tick();
    end
    wr_en_i = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_burst(vecs[i]);

    // zero length
    start_i = 1'b1;
    len_i   = '0;
    tick();
    start_i = 1'b0;
    check("zero_done", done_o, 1);
    check("zero_valid", m_valid_o, 0);
    tick();
    check("zero_idle", idle_o, 1);
    check("zero_done_clr", done_o, 0);
    check("zero_valid2", m_valid_o, 0);

    // backpressure, ready pattern 1,0,0,1
    pat         = 4'b1001;
    start_i     = 1'b1;
    base_addr_i = '0;
    len_i       = 8'd8;
    stride_i    = 7'd1;
    m_ready_i   = 1'b0;
    tick();
    start_i = 1'b0;
    k       = 0;
    held    = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      m_ready_i = pat[3 - (c % 4)];
      if (held) begin
        check("bp_valid_hold", m_valid_o, 1);
        check("bp_data_hold", m_data_o, held_data);
        check("bp_last_hold", m_last_o, held_last);
      end
      if (m_valid_o) begin
        check("bp_no_done", done_o, 0);
        if (m_ready_i) begin
          check("bp_data", m_data_o, 100 + k);
          check("bp_last", m_last_o, (k == 7) ? 1 : 0);
          k++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = m_data_o;
          held_last = m_last_o;
        end
      end
      tick();
    end
    check("bp_beats", k, 8);
    check("bp_done", done_o, 1);
    m_ready_i = 1'b1;
    tick();
    check("bp_idle", idle_o, 1);

    // abort after third handshake
    start_i     = 1'b1;
    base_addr_i = 7'd10;
    len_i       = 8'd20;
    stride_i    = 7'd1;
    m_ready_i   = 1'b1;
    tick();
    start_i = 1'b0;
    hs      = 0;
    for (int c = 0; c < 20 && hs < 3; c++) begin
      if (m_valid_o) begin
        check("abort_pre_data", m_data_o, 110 + hs);
        hs++;
      end
      tick();
    end
    check("abort_hs", hs, 3);
    check("abort_valid_before", m_valid_o, 1);
    abort_i   = 1'b1;
    m_ready_i = 1'b0;
    tick();
    abort_i = 1'b0;
    check("abort_valid", m_valid_o, 0);
    check("abort_idle", idle_o, 1);
    check("abort_no_done", done_o, 0);
    tick();
    check("abort_idle2", idle_o, 1);
    check("abort_no_done2", done_o, 0);
    check("abort_valid2", m_valid_o, 0);
    run_burst(vecs[0]);

    // reset while draining
    start_i     = 1'b1;
    base_addr_i = '0;
    len_i       = 8'd2;
    stride_i    = 7'd1;
    m_ready_i   = 1'b0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    check("drain_run", run_o, 1);
    check("drain_valid", m_valid_o, 1);
    rst = 1'b1;
    tick();
    check("mrst_idle", idle_o, 1);
    check("mrst_run", run_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_valid", m_valid_o, 0);
    check("mrst_last", m_last_o, 0);
    check("mrst_data", m_data_o, 0);
    rst       = 1'b0;
    m_ready_i = 1'b1;
    tick();
    check("mrst_no_done", done_o, 0);
    check("mrst_idle2", idle_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
